// File: rtl/square_sequencer.sv
// Frame-synchronous control FSM for the square display: turns debounced buttons into
// select/zoom/back events and applies them only on the frame tick.
module square_sequencer #(
    parameter int NUM_SQUARES         = 4,
    parameter int IDX_W               = 4,
    parameter int FULL_TIMEOUT_FRAMES = 600,
    parameter int TMR_W               = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_tick,
    input  logic             btn_next,
    input  logic             btn_enter,
    input  logic             btn_back,
    output logic [IDX_W-1:0] square_index,
    output logic             square_select,
    output logic             full_screen,
    output logic             timeout_active
);

    typedef enum logic [1:0] {
        IDLE,
        SELECT,
        FULL
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_SQUARES - 1);
    localparam logic [TMR_W-1:0] TIMEOUT    = TMR_W'(FULL_TIMEOUT_FRAMES);
    localparam bit               TIMEOUT_EN = (FULL_TIMEOUT_FRAMES != 0);

    state_t           state, state_n;
    logic [IDX_W-1:0] index_n;
    logic [TMR_W-1:0] tmr, tmr_n, tmr_inc;
    logic             prev_next, prev_enter, prev_back;
    logic             pend_next, pend_enter, pend_back;
    logic             ev_next, ev_enter, ev_back;
    logic             eff_next, eff_enter, eff_back;

    assign ev_next   = btn_next  & ~prev_next;
    assign ev_enter  = btn_enter & ~prev_enter;
    assign ev_back   = btn_back  & ~prev_back;
    assign eff_next  = pend_next  | ev_next;
    assign eff_enter = pend_enter | ev_enter;
    assign eff_back  = pend_back  | ev_back;
    assign tmr_inc   = tmr + TMR_W'(1);

    // Prev registers always track the button, so a level held through reset never edges.
    always_ff @(posedge clk) begin
        prev_next  <= btn_next;
        prev_enter <= btn_enter;
        prev_back  <= btn_back;
        if (reset || frame_tick) begin
            pend_next  <= 1'b0;
            pend_enter <= 1'b0;
            pend_back  <= 1'b0;
        end else begin
            pend_next  <= pend_next  | ev_next;
            pend_enter <= pend_enter | ev_enter;
            pend_back  <= pend_back  | ev_back;
        end
    end

    // Only the highest-priority effective event acts; the rest are consumed silently.
    always_comb begin
        state_n = state;
        index_n = square_index;
        tmr_n   = tmr;
        if (frame_tick) begin
            case (state)
                IDLE: begin
                    if (!eff_back && (eff_enter || eff_next))
                        state_n = SELECT;
                end
                SELECT: begin
                    if (eff_back) begin
                        state_n = IDLE;
                    end else if (eff_enter) begin
                        state_n = FULL;
                        tmr_n   = '0;
                    end else if (eff_next) begin
                        index_n = (square_index == LAST_IDX) ? '0 : square_index + IDX_W'(1);
                    end
                end
                FULL: begin
                    if (eff_back) begin
                        state_n = SELECT;
                        tmr_n   = '0;
                    end else if (TIMEOUT_EN) begin
                        if (tmr_inc == TIMEOUT) begin
                            state_n = SELECT;
                            tmr_n   = '0;
                        end else begin
                            tmr_n = tmr_inc;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            square_index   <= '0;
            tmr            <= '0;
            square_select  <= 1'b0;
            full_screen    <= 1'b0;
            timeout_active <= 1'b0;
        end else begin
            state          <= state_n;
            square_index   <= index_n;
            tmr            <= tmr_n;
            square_select  <= (state_n != IDLE);
            full_screen    <= (state_n == FULL);
            timeout_active <= (state_n == FULL) && TIMEOUT_EN;
        end
    end

endmodule

// File: tb/tb_square_sequencer.sv
// Directed bench for square_sequencer: one instance with a 3-frame timeout and one with
// the timeout disabled, both driven by the same button and tick stimulus.
module tb_square_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       frame_tick = 1'b0;
    logic       btn_next = 1'b0;
    logic       btn_enter = 1'b0;
    logic       btn_back = 1'b0;
    logic [3:0] idx_a, idx_b;
    logic       sel_a, sel_b, full_a, full_b, to_a, to_b;
    int         tests_run = 0;
    int         tests_failed = 0;

    always #5 clk = ~clk;

    square_sequencer #(.NUM_SQUARES(4), .IDX_W(4), .FULL_TIMEOUT_FRAMES(3), .TMR_W(10)) dut_a (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .btn_next(btn_next), .btn_enter(btn_enter), .btn_back(btn_back),
        .square_index(idx_a), .square_select(sel_a), .full_screen(full_a), .timeout_active(to_a)
    );

    square_sequencer #(.NUM_SQUARES(4), .IDX_W(4), .FULL_TIMEOUT_FRAMES(0), .TMR_W(10)) dut_b (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .btn_next(btn_next), .btn_enter(btn_enter), .btn_back(btn_back),
        .square_index(idx_b), .square_select(sel_b), .full_screen(full_b), .timeout_active(to_b)
    );

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // One-cycle pulse on the chosen inputs; returns on the falling edge after the sampling edge.
    task automatic applyStimulus(input logic n, input logic e, input logic b, input logic t);
        @(negedge clk);
        btn_next   = n;
        btn_enter  = e;
        btn_back   = b;
        frame_tick = t;
        @(negedge clk);
        btn_next   = 1'b0;
        btn_enter  = 1'b0;
        btn_back   = 1'b0;
        frame_tick = 1'b0;
    endtask

    initial begin
        // Reset with next held, then idle ticks: must stay IDLE.
        @(negedge clk);
        reset    = 1'b1;
        btn_next = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
        end
        checkOutput("reset_sel", 8'(sel_a), 8'd0);
        checkOutput("reset_full", 8'(full_a), 8'd0);
        checkOutput("reset_idx", 8'(idx_a), 8'd0);
        checkOutput("reset_to", 8'(to_a), 8'd0);
        @(negedge clk);
        btn_next = 1'b0;
        @(negedge clk);

        // Select and wrap.
        applyStimulus(1, 0, 0, 0);
        checkOutput("gate_before_tick", 8'(sel_a), 8'd0);
        applyStimulus(0, 0, 0, 1);
        checkOutput("select_sel", 8'(sel_a), 8'd1);
        checkOutput("select_idx0", 8'(idx_a), 8'd0);
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1, 0, 0, 0);
            applyStimulus(0, 0, 0, 1);
            checkOutput($sformatf("wrap_idx_%0d", i), 8'(idx_a), 8'(i % 4));
        end

        // Move to index 2, then next+enter+back in one frame: back wins.
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 0, 0, 1);
        checkOutput("prio_setup_idx", 8'(idx_a), 8'd2);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 0, 1, 0);
        checkOutput("prio_hold_sel", 8'(sel_a), 8'd1);
        checkOutput("prio_hold_idx", 8'(idx_a), 8'd2);
        applyStimulus(0, 0, 0, 1);
        checkOutput("prio_sel", 8'(sel_a), 8'd0);
        checkOutput("prio_full", 8'(full_a), 8'd0);
        checkOutput("prio_idx", 8'(idx_a), 8'd2);

        // IDLE -> SELECT keeps index; then full-screen entry, ignored next, back.
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 0, 0, 1);
        checkOutput("reselect_idx", 8'(idx_a), 8'd2);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 0, 0, 1);
        checkOutput("full_full", 8'(full_a), 8'd1);
        checkOutput("full_sel", 8'(sel_a), 8'd1);
        checkOutput("full_to_a", 8'(to_a), 8'd1);
        checkOutput("full_to_b", 8'(to_b), 8'd0);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 0, 0, 1);
        checkOutput("full_next_idx", 8'(idx_a), 8'd2);
        checkOutput("full_next_full", 8'(full_a), 8'd1);
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 0, 1);
        checkOutput("back_full", 8'(full_a), 8'd0);
        checkOutput("back_sel", 8'(sel_a), 8'd1);
        checkOutput("back_b_full", 8'(full_b), 8'd0);

        // Timeout of 3 frames on dut_a; dut_b never times out.
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("tmo_2nd_full", 8'(full_a), 8'd1);
        checkOutput("tmo_2nd_to", 8'(to_a), 8'd1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("tmo_3rd_full", 8'(full_a), 8'd0);
        checkOutput("tmo_3rd_to", 8'(to_a), 8'd0);
        checkOutput("tmo_3rd_sel", 8'(sel_a), 8'd1);
        for (int i = 0; i < 1000; i++) applyStimulus(0, 0, 0, 1);
        checkOutput("notmo_full_b", 8'(full_b), 8'd1);
        checkOutput("notmo_to_b", 8'(to_b), 8'd0);
        checkOutput("notmo_full_a", 8'(full_a), 8'd0);

        // Several next presses in one frame count once; edge coincident with tick acts.
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 0, 0, 1);
        checkOutput("multi_idx_a", 8'(idx_a), 8'd3);
        checkOutput("multi_idx_b", 8'(idx_b), 8'd2);
        applyStimulus(1, 0, 0, 1);
        checkOutput("sametick_idx", 8'(idx_a), 8'd0);

        // Reset mid-FULL with back pending and a coincident tick.
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 0, 0, 1);
        checkOutput("pre_reset_full", 8'(full_a), 8'd1);
        applyStimulus(0, 0, 1, 0);
        @(negedge clk);
        reset      = 1'b1;
        frame_tick = 1'b1;
        @(negedge clk);
        reset      = 1'b0;
        frame_tick = 1'b0;
        checkOutput("rst_sel", 8'(sel_a), 8'd0);
        checkOutput("rst_full", 8'(full_a), 8'd0);
        checkOutput("rst_to", 8'(to_a), 8'd0);
        checkOutput("rst_idx", 8'(idx_a), 8'd0);
        checkOutput("rst_full_b", 8'(full_b), 8'd0);
        applyStimulus(0, 0, 0, 1);
        checkOutput("post_rst_sel", 8'(sel_a), 8'd0);
        checkOutput("post_rst_full", 8'(full_a), 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
